// File: rtl/lstm_cell_update.sv
// LSTM cell-state / hidden-state update: c = f*c_prev + i*g, h = o*tanh(c).
// Elements flow one per cycle through a 3-stage fixed-point pipeline.
module lstm_cell_update #(
    parameter int HIDDEN_SZ      = 16,
    parameter int QN             = 6,
    parameter int QM             = 11,
    parameter int LAYER_BITWIDTH = (QN + QM + 1) * HIDDEN_SZ
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      beginCalc,
    input  logic [LAYER_BITWIDTH-1:0] inputGate,
    input  logic [LAYER_BITWIDTH-1:0] forgetGate,
    input  logic [LAYER_BITWIDTH-1:0] candGate,
    input  logic [LAYER_BITWIDTH-1:0] outputGate,
    output logic [LAYER_BITWIDTH-1:0] hiddenOut,
    output logic [LAYER_BITWIDTH-1:0] cellOut,
    output logic                      dataReady,
    output logic [1:0]                state_o
);
    localparam int BW = QN + QM + 1;
    localparam int CW = (HIDDEN_SZ > 1) ? $clog2(HIDDEN_SZ) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(HIDDEN_SZ - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [BW-1:0] SAT_MAX = {1'b0, {(BW-1){1'b1}}};
    localparam logic [BW-1:0] SAT_MIN = {1'b1, {(BW-1){1'b0}}};
    localparam logic signed [2*BW-1:0] MUL_MAX = {{(BW+1){1'b0}}, {(BW-1){1'b1}}};
    localparam logic signed [2*BW-1:0] MUL_MIN = {{(BW+1){1'b1}}, {(BW-1){1'b0}}};
    // tanh breakpoints 0.5 and 2.5, slope offset 0.375, ceiling 1.0
    localparam logic [BW:0] HALF_W = (BW+1)'(2 ** (QM - 1));
    localparam logic [BW:0] KNEE_W = (BW+1)'(5 * (2 ** (QM - 1)));
    localparam logic [BW:0] OFF_W  = (BW+1)'(3 * (2 ** (QM - 3)));
    localparam logic [BW:0] ONE_W  = (BW+1)'(2 ** QM);

    function automatic logic [BW-1:0] fx_mul(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic signed [2*BW-1:0] p;
        logic [BW-1:0] r;
        p = $signed(a) * $signed(b);
        p = p >>> QM;
        if (p > MUL_MAX)      r = SAT_MAX;
        else if (p < MUL_MIN) r = SAT_MIN;
        else                  r = p[BW-1:0];
        return r;
    endfunction

    function automatic logic [BW-1:0] fx_add(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [BW:0] s;
        logic [BW-1:0] r;
        s = {a[BW-1], a} + {b[BW-1], b};
        if (s[BW] != s[BW-1]) r = s[BW] ? SAT_MIN : SAT_MAX;
        else                  r = s[BW-1:0];
        return r;
    endfunction

    function automatic logic [BW-1:0] fx_tanh(input logic [BW-1:0] x);
        logic [BW:0] xe, mag, y;
        logic [BW-1:0] r;
        xe  = {x[BW-1], x};
        mag = x[BW-1] ? (~xe + 1'b1) : xe;
        y   = '0;
        if (mag < HALF_W) begin
            r = x;
        end else begin
            if (mag < KNEE_W) y = OFF_W + (mag >> 2);
            else              y = ONE_W;
            r = x[BW-1] ? (~y[BW-1:0] + 1'b1) : y[BW-1:0];
        end
        return r;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic          latch_en, issue;

    logic [LAYER_BITWIDTH-1:0] i_q, f_q, g_q, o_q;
    logic [LAYER_BITWIDTH-1:0] cell_q, hid_q;

    logic          s1_valid_q, s1_last_q, s2_valid_q, s2_last_q, s3_last_q;
    logic [CW-1:0] s1_idx_q, s2_idx_q;
    logic [BW-1:0] s1_fc_q, s1_ig_q, s2_c_q, s2_t_q;
    logic [BW-1:0] c_sum;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        latch_en = 1'b0;
        issue    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (beginCalc) begin
                    latch_en = 1'b1;
                    ready_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                issue = 1'b1;
                if (cnt_q == LAST_IDX) state_d = S_DRAIN;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_DRAIN: begin
                if (s3_last_q) begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Gates are sampled once at start so callers may move on immediately.
    always_ff @(posedge clock) begin
        if (latch_en) begin
            i_q <= inputGate;
            f_q <= forgetGate;
            g_q <= candGate;
            o_q <= outputGate;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s3_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= issue;
            s1_last_q  <= issue && (cnt_q == LAST_IDX);
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            s3_last_q  <= s2_valid_q && s2_last_q;
        end
    end

    assign c_sum = fx_add(s1_fc_q, s1_ig_q);

    always_ff @(posedge clock) begin
        s1_idx_q <= cnt_q;
        s1_fc_q  <= fx_mul(f_q[int'(cnt_q)*BW +: BW], cell_q[int'(cnt_q)*BW +: BW]);
        s1_ig_q  <= fx_mul(i_q[int'(cnt_q)*BW +: BW], g_q[int'(cnt_q)*BW +: BW]);
        s2_idx_q <= s1_idx_q;
        s2_c_q   <= c_sum;
        s2_t_q   <= fx_tanh(c_sum);
    end

    // Element j of c_prev is read in S1 before its own S3 write-back this run.
    always_ff @(posedge clock) begin
        if (reset) begin
            cell_q <= '0;
            hid_q  <= '0;
        end else if (s2_valid_q) begin
            cell_q[int'(s2_idx_q)*BW +: BW] <= s2_c_q;
            hid_q[int'(s2_idx_q)*BW +: BW]  <= fx_mul(o_q[int'(s2_idx_q)*BW +: BW], s2_t_q);
        end
    end

    assign hiddenOut = hid_q;
    assign cellOut   = cell_q;
    assign dataReady = ready_q;
    assign state_o   = state_q;
endmodule

// File: doc/lstm_cell_update.md
LSTM_CELL_UPDATE -- requirements
Module: lstm_cell_update

Interface
REQ-001 Parameter HIDDEN_SZ, default 16, number of hidden units (elements per vector).
REQ-002 Parameter QN, default 6, integer bits of the signed fixed-point format.
REQ-003 Parameter QM, default 11, fractional bits; BITWIDTH = QN+QM+1 (18), LAYER_BITWIDTH = BITWIDTH*HIDDEN_SZ.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 beginCalc  input  1  start pulse; sampled only in IDLE or DONE.
REQ-007 inputGate  input  LAYER_BITWIDTH  i vector; element j at [j*BITWIDTH +: BITWIDTH].
REQ-008 forgetGate  input  LAYER_BITWIDTH  f vector, same packing.
REQ-009 candGate  input  LAYER_BITWIDTH  g (candidate) vector, same packing.
REQ-010 outputGate  input  LAYER_BITWIDTH  o vector, same packing.
REQ-011 hiddenOut  output  LAYER_BITWIDTH  h_t vector, same packing.
REQ-012 cellOut  output  LAYER_BITWIDTH  c_t vector (internal cell state), same packing.
REQ-013 dataReady  output  1  high when hiddenOut/cellOut hold a completed result.

Function
REQ-014 Per element j: c_t = f*c_prev + i*g; h_t = o*tanh_pwl(c_t); c_prev is the stored cellOut element.
REQ-015 All values are two's-complement Q(QN).(QM); 1.0 = 2^QM (2048).
REQ-016 Multiply: full 2*BITWIDTH product, arithmetic shift right by QM (truncate), saturate to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
REQ-017 Add: BITWIDTH+1-bit sum, saturate to the same range.
REQ-018 tanh_pwl(x): |x|<0.5 -> x; 0.5<=|x|<2.5 -> sign(x)*(0.375 + |x|/4) (|x| shifted right 2, truncate); |x|>=2.5 -> sign(x)*1.0.
REQ-019 States: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE/DONE + beginCalc=1: latch all four gate vectors into internal registers, clear dataReady, element counter := 0, go RUN.
REQ-021 RUN: one element issued per cycle, index 0..HIDDEN_SZ-1 ascending; after index HIDDEN_SZ-1 go DRAIN.
REQ-022 Pipeline 3 stages: S1 products f*c_prev and i*g; S2 sum/saturate -> c_t, tanh_pwl; S3 o*tanh -> h_t; c_t and h_t written to element j of cellOut/hiddenOut at S3.
REQ-023 DRAIN: wait until last element retires from S3, then go DONE.
REQ-024 Latency: dataReady rises exactly HIDDEN_SZ+3 rising edges after the edge sampling beginCalc=1 (19 for defaults).
REQ-025 dataReady holds high in DONE until next accepted beginCalc or reset; outputs stable in DONE.
REQ-026 beginCalc during RUN/DRAIN: ignored, no effect on counter, latches or outputs.
REQ-027 Gate inputs may change after the beginCalc edge; only latched copies are used.
REQ-028 cellOut persists across runs (recurrence); only reset clears it.
REQ-029 Counter wraps never: it stops at HIDDEN_SZ-1, no reissue of element 0.

Reset
REQ-030 reset=1 at a rising edge: state := IDLE, counter := 0, dataReady := 0, hiddenOut := 0, cellOut := 0, pipeline valid bits := 0.
REQ-031 reset has priority over beginCalc in the same cycle; reset mid-RUN/DRAIN aborts, no partial result flagged.

Verification
REQ-032 Reset 2 cycles -> dataReady=0, hiddenOut=0, cellOut=0 for all elements.
REQ-033 After reset, i=2048, f=0, g=1024, o=2048 all elements, beginCalc 1 cycle -> dataReady high on edge 19, every cellOut element 1024, hiddenOut element 1024.
REQ-034 Follow-up run, i=2048, f=2048, g=1024, o=2048 -> cellOut 2048, hiddenOut 1280 (0.375+0.25).
REQ-035 i=2048, f=0, g=-6144 (-3.0), o=2048 -> cellOut -6144, hiddenOut -2048; o=1024 instead -> hiddenOut -1024.
REQ-036 i=2048, f=2048, g=0x1FFFF, o=2048, repeated 3 runs -> cellOut saturates at 131071 (0x1FFFF), no wrap negative, hiddenOut 2048.
REQ-037 beginCalc again at cycle 5 of RUN -> ignored, dataReady still at edge 19; separate run with reset at cycle 5 -> dataReady stays 0, cellOut 0, next beginCalc completes normally in 19 cycles.
